// File: rtl/gpu_sram_port_arb.sv
// gpu_sram_port_arb
// Shares the single GPU-SRAM framebuffer port between the rasterizer
// (requester 0) and the clear/fill engine (requester 1). Accesses are issued
// only during blanking (I_VIDEO_ON low). A granted requester keeps the port
// for up to MAX_BURST consecutive beats. Each accepted request drives one
// registered SRAM strobe in the following cycle. Read data returns two
// cycles after the handshake.
//
// Build option: define GPU_ARB_FIXED_PRIO_EN to make requester 0 always win
// IDLE arbitration when both requesters are valid. The default build uses
// round-robin arbitration.
module gpu_sram_port_arb #(
    parameter int ADDR_W    = 18,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 16   // legal range 1..255
) (
    input  logic              I_CLK,
    input  logic              I_RST_N,
    input  logic              I_VIDEO_ON,

    input  logic              I_REQ0_VALID,
    output logic              O_REQ0_READY,
    input  logic [ADDR_W-1:0] I_REQ0_ADDR,
    input  logic [DATA_W-1:0] I_REQ0_WDATA,
    input  logic              I_REQ0_WE,

    input  logic              I_REQ1_VALID,
    output logic              O_REQ1_READY,
    input  logic [ADDR_W-1:0] I_REQ1_ADDR,
    input  logic [DATA_W-1:0] I_REQ1_WDATA,
    input  logic              I_REQ1_WE,

    output logic              O_RSP0_VALID,
    output logic              O_RSP1_VALID,
    output logic [DATA_W-1:0] O_RSP_DATA,

    input  logic [DATA_W-1:0] I_GPU_DATA,
    output logic [ADDR_W-1:0] O_GPU_ADDR,
    output logic [DATA_W-1:0] O_GPU_DATA,
    output logic              O_GPU_READ,
    output logic              O_GPU_WRITE
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST);

    state_t      state, state_nxt;
    logic        last, last_nxt;      // previous owner; 1 after reset so req0 wins first
    logic [7:0]  beats, beats_nxt;

    logic        ready0, ready1;
    logic        xfer0, xfer1, xfer;
    logic        own_id;

    logic [ADDR_W-1:0] gpu_addr;
    logic [DATA_W-1:0] gpu_data;
    logic              gpu_read, gpu_write;
    logic              rd_id;         // requester that owns the read strobe in flight
    logic              rsp_valid0, rsp_valid1;
    logic [DATA_W-1:0] rsp_data;

    // Combinational grant: depends only on VALIDs, video state, FSM state and reset.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        ready0 = 1'b0;
        ready1 = 1'b0;
        // Reset is included so READY is low while reset is asserted.
        if (I_RST_N && !I_VIDEO_ON) begin
            case (state)
                IDLE: begin
                    if (I_REQ0_VALID && I_REQ1_VALID) begin
`ifdef GPU_ARB_FIXED_PRIO_EN
                        ready0 = 1'b1;
`else
                        ready0 = last;
                        ready1 = !last;
`endif
                    end else begin
                        ready0 = I_REQ0_VALID;
                        ready1 = I_REQ1_VALID;
                    end
                end
                OWN0:    ready0 = I_REQ0_VALID;
                OWN1:    ready1 = I_REQ1_VALID;
                default: ;
            endcase
        end
    end

    assign xfer0  = I_REQ0_VALID && ready0;
    assign xfer1  = I_REQ1_VALID && ready1;
    assign xfer   = xfer0 || xfer1;
    assign own_id = (state == OWN1);

    // Next-state logic: burst ownership, beat counting and owner history.
    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        beats_nxt = beats;
        if (I_VIDEO_ON) begin
            state_nxt = IDLE;
            beats_nxt = 8'd0;
            if (state != IDLE) begin
                last_nxt = own_id;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        if (MAX_BURST == 1) begin
                            last_nxt = xfer1;
                        end else begin
                            state_nxt = xfer1 ? OWN1 : OWN0;
                            beats_nxt = 8'd1;
                        end
                    end
                end
                OWN0, OWN1: begin
                    if (xfer) begin
                        beats_nxt = beats + 8'd1;
                        if (beats + 8'd1 == BURST_LAST) begin
                            state_nxt = IDLE;
                            last_nxt  = own_id;
                            beats_nxt = 8'd0;
                        end
                    end else begin
                        // Owner dropped VALID: give the port back after this bubble.
                        state_nxt = IDLE;
                        last_nxt  = own_id;
                        beats_nxt = 8'd0;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    beats_nxt = 8'd0;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            state <= IDLE;
            last  <= 1'b1;
            beats <= 8'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state <= state_nxt;
            last  <= last_nxt;
            beats <= beats_nxt;
        end
    end

    // SRAM command stage: one strobe in the cycle after each accepted request.
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            // NOTE: the address/data registers are reset too, because they drive outputs that must be 0 in reset.
            gpu_addr  <= '0;
            gpu_data  <= '0;
            gpu_read  <= 1'b0;
            gpu_write <= 1'b0;
            rd_id     <= 1'b0;
        end else begin
            gpu_read  <= 1'b0;
            gpu_write <= 1'b0;
            if (xfer) begin
                gpu_addr  <= xfer1 ? I_REQ1_ADDR  : I_REQ0_ADDR;
                gpu_data  <= xfer1 ? I_REQ1_WDATA : I_REQ0_WDATA;
                gpu_write <= xfer1 ? I_REQ1_WE    : I_REQ0_WE;
                gpu_read  <= xfer1 ? !I_REQ1_WE   : !I_REQ0_WE;
                rd_id     <= xfer1;
            end
        end
    end

    // Read return stage: capture SRAM data at the end of the read strobe cycle.
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            rsp_valid0 <= 1'b0;
            rsp_valid1 <= 1'b0;
            rsp_data   <= '0;
        end else begin
            rsp_valid0 <= gpu_read && !rd_id;
            rsp_valid1 <= gpu_read &&  rd_id;
            if (gpu_read) begin
                rsp_data <= I_GPU_DATA;
            end
        end
    end

    assign O_REQ0_READY = ready0;
    assign O_REQ1_READY = ready1;
    assign O_GPU_ADDR   = gpu_addr;
    assign O_GPU_DATA   = gpu_data;
    assign O_GPU_READ   = gpu_read;
    assign O_GPU_WRITE  = gpu_write;
    assign O_RSP0_VALID = rsp_valid0;
    assign O_RSP1_VALID = rsp_valid1;
    assign O_RSP_DATA   = rsp_data;

endmodule

// File: tb/tb_gpu_sram_port_arb.sv
// Directed testbench for gpu_sram_port_arb (MAX_BURST = 4).
// Inputs change on the falling edge. Registered outputs are observed on the
// falling edge. READY is observed 1 ns after the inputs change.
`timescale 1ns/1ps
module tb_gpu_sram_port_arb;

    localparam int ADDR_W    = 18;
    localparam int DATA_W    = 16;
    localparam int MAX_BURST = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              video_on;
    logic              req0_valid, req0_ready, req0_we;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              req1_valid, req1_ready, req1_we;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              rsp0_valid, rsp1_valid;
    logic [DATA_W-1:0] rsp_data;
    logic [DATA_W-1:0] gpu_rdata;
    logic [ADDR_W-1:0] gpu_addr;
    logic [DATA_W-1:0] gpu_wdata;
    logic              gpu_read, gpu_write;

    int n_cmp = 0;
    int n_bad = 0;

    gpu_sram_port_arb #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .I_CLK        (clk),
        .I_RST_N      (rst_n),
        .I_VIDEO_ON   (video_on),
        .I_REQ0_VALID (req0_valid),
        .O_REQ0_READY (req0_ready),
        .I_REQ0_ADDR  (req0_addr),
        .I_REQ0_WDATA (req0_wdata),
        .I_REQ0_WE    (req0_we),
        .I_REQ1_VALID (req1_valid),
        .O_REQ1_READY (req1_ready),
        .I_REQ1_ADDR  (req1_addr),
        .I_REQ1_WDATA (req1_wdata),
        .I_REQ1_WE    (req1_we),
        .O_RSP0_VALID (rsp0_valid),
        .O_RSP1_VALID (rsp1_valid),
        .O_RSP_DATA   (rsp_data),
        .I_GPU_DATA   (gpu_rdata),
        .O_GPU_ADDR   (gpu_addr),
        .O_GPU_DATA   (gpu_wdata),
        .O_GPU_READ   (gpu_read),
        .O_GPU_WRITE  (gpu_write)
    );

    // SRAM model: read data is a fixed function of the address.
    function automatic logic [DATA_W-1:0] sram_model(input logic [ADDR_W-1:0] a);
        if (a == 18'h3FFFF) return 16'hABCD;
        return a[15:0] ^ 16'hC3C3;
    endfunction

    assign gpu_rdata = sram_model(gpu_addr);

    task automatic idle_inputs();
        video_on   = 1'b0;
        req0_valid = 1'b0; req0_addr = '0; req0_wdata = '0; req0_we = 1'b0;
        req1_valid = 1'b0; req1_addr = '0; req1_wdata = '0; req1_we = 1'b0;
    endtask

    // The task returns on a falling edge with reset just released.
    task automatic apply_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; video_on = 1'b0;
        req0_valid = 1'b1; req0_addr = 18'h00111; req0_wdata = 16'h1111; req0_we = 1'b1;
        req1_valid = 1'b1; req1_addr = 18'h00222; req1_wdata = 16'h2222; req1_we = 1'b1;
        @(negedge clk); #1;
        n_cmp++;
        if ({req0_ready, req1_ready, gpu_read, gpu_write, rsp0_valid, rsp1_valid} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {req0_ready, req1_ready, gpu_read, gpu_write, rsp0_valid, rsp1_valid});
        end
        n_cmp++;
        if (gpu_addr !== 18'h0) begin n_bad++; $display("FAIL reset_addr: got %h expected 0", gpu_addr); end
        n_cmp++;
        if (gpu_wdata !== 16'h0) begin n_bad++; $display("FAIL reset_wdata: got %h expected 0", gpu_wdata); end
        n_cmp++;
        if (rsp_data !== 16'h0) begin n_bad++; $display("FAIL reset_rsp_data: got %h expected 0", rsp_data); end
        // Release reset with both requesters valid: requester 0 must win.
        rst_n = 1'b1; #1;
        n_cmp++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_bad++; $display("FAIL reset_first_grant: got %b expected 10", {req0_ready, req1_ready});
        end
        @(negedge clk);
        n_cmp++;
        if ({gpu_read, gpu_write, gpu_addr, gpu_wdata} !== {2'b01, 18'h00111, 16'h1111}) begin
            n_bad++; $display("FAIL reset_first_strobe: got rw=%b addr=%h data=%h expected rw=01 addr=00111 data=1111",
                              {gpu_read, gpu_write}, gpu_addr, gpu_wdata);
        end
        idle_inputs();
    endtask

    task automatic test_single_write();
        apply_reset();
        req0_valid = 1'b1; req0_addr = 18'h00123; req0_wdata = 16'hF0F0; req0_we = 1'b1;
        #1;
        n_cmp++;
        if (req0_ready !== 1'b1) begin n_bad++; $display("FAIL sw_ready: got %b expected 1", req0_ready); end
        @(negedge clk);
        req0_valid = 1'b0;
        n_cmp++;
        if ({gpu_read, gpu_write, gpu_addr, gpu_wdata} !== {2'b01, 18'h00123, 16'hF0F0}) begin
            n_bad++; $display("FAIL sw_strobe: got rw=%b addr=%h data=%h expected rw=01 addr=00123 data=f0f0",
                              {gpu_read, gpu_write}, gpu_addr, gpu_wdata);
        end
        @(negedge clk);
        n_cmp++;
        if ({gpu_read, gpu_write, gpu_addr} !== {2'b00, 18'h00123}) begin
            n_bad++; $display("FAIL sw_after: got rw=%b addr=%h expected rw=00 addr=00123",
                              {gpu_read, gpu_write}, gpu_addr);
        end
        idle_inputs();
    endtask

    task automatic test_read_return();
        apply_reset();
        req1_valid = 1'b1; req1_addr = 18'h3FFFF; req1_we = 1'b0;
        #1;
        n_cmp++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            n_bad++; $display("FAIL rd_ready: got %b expected 01", {req0_ready, req1_ready});
        end
        @(negedge clk);
        req1_valid = 1'b0;
        n_cmp++;
        if ({gpu_read, gpu_write, gpu_addr, rsp1_valid} !== {2'b10, 18'h3FFFF, 1'b0}) begin
            n_bad++; $display("FAIL rd_strobe: got rw=%b addr=%h rsp1=%b expected rw=10 addr=3ffff rsp1=0",
                              {gpu_read, gpu_write}, gpu_addr, rsp1_valid);
        end
        @(negedge clk);
        n_cmp++;
        if ({rsp0_valid, rsp1_valid, gpu_read, rsp_data} !== {3'b010, 16'hABCD}) begin
            n_bad++; $display("FAIL rd_rsp: got rsp0=%b rsp1=%b rd=%b data=%h expected rsp0=0 rsp1=1 rd=0 data=abcd",
                              rsp0_valid, rsp1_valid, gpu_read, rsp_data);
        end
        @(negedge clk);
        n_cmp++;
        if ({rsp0_valid, rsp1_valid} !== 2'b00) begin
            n_bad++; $display("FAIL rd_rsp_once: got %b expected 00", {rsp0_valid, rsp1_valid});
        end
        idle_inputs();
    endtask

    task automatic test_round_robin();
        apply_reset();
        for (int k = 0; k < 12; k++) begin
            int owner;
            logic [ADDR_W-1:0] exp_addr;
`ifdef GPU_ARB_FIXED_PRIO_EN
            owner = 0;
`else
            owner = (k / 4) % 2;
`endif
            exp_addr = (owner == 1) ? (18'h20000 | 18'(k)) : (18'h10000 | 18'(k));
            req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 18'h10000 | 18'(k); req0_wdata = 16'h0A00 | 16'(k);
            req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 18'h20000 | 18'(k); req1_wdata = 16'h0B00 | 16'(k);
            #1;
            n_cmp++;
            if ({req0_ready, req1_ready} !== ((owner == 1) ? 2'b01 : 2'b10)) begin
                n_bad++; $display("FAIL rr_ready[%0d]: got %b expected owner %0d", k, {req0_ready, req1_ready}, owner);
            end
            @(negedge clk);
            n_cmp++;
            if ({gpu_read, gpu_write, gpu_addr} !== {2'b01, exp_addr}) begin
                n_bad++; $display("FAIL rr_strobe[%0d]: got rw=%b addr=%h expected rw=01 addr=%h",
                                  k, {gpu_read, gpu_write}, gpu_addr, exp_addr);
            end
        end
        idle_inputs();
    endtask

    task automatic test_burst_bubble();
        apply_reset();
        req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 18'h00400; req1_wdata = 16'h4444;
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 18'h00300; req0_wdata = 16'h3333;
        for (int c = 0; c < 4; c++) begin
            logic [1:0]        exp_rdy;
            logic [1:0]        exp_rw;
            logic [ADDR_W-1:0] exp_addr;
            if (c == 1) req0_addr = 18'h00301;
            if (c == 2) req0_valid = 1'b0;
            exp_rdy  = (c < 2) ? 2'b10 : ((c == 2) ? 2'b00 : 2'b01);
            exp_rw   = (c == 2) ? 2'b00 : 2'b01;
            exp_addr = (c == 0) ? 18'h00300 : ((c == 3) ? 18'h00400 : 18'h00301);
            #1;
            n_cmp++;
            if ({req0_ready, req1_ready} !== exp_rdy) begin
                n_bad++; $display("FAIL bubble_ready[%0d]: got %b expected %b", c, {req0_ready, req1_ready}, exp_rdy);
            end
            @(negedge clk);
            n_cmp++;
            if ({gpu_read, gpu_write, gpu_addr} !== {exp_rw, exp_addr}) begin
                n_bad++; $display("FAIL bubble_strobe[%0d]: got rw=%b addr=%h expected rw=%b addr=%h",
                                  c, {gpu_read, gpu_write}, gpu_addr, exp_rw, exp_addr);
            end
        end
        idle_inputs();
    endtask

    task automatic test_blanking();
        apply_reset();
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 18'h00050;
        #1;
        n_cmp++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            n_bad++; $display("FAIL blank_ready0: got %b expected 01", {req0_ready, req1_ready});
        end
        @(negedge clk);
        req1_addr = 18'h00051;
        #1;
        n_cmp++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            n_bad++; $display("FAIL blank_ready1: got %b expected 01", {req0_ready, req1_ready});
        end
        @(negedge clk);
        n_cmp++;
        if ({gpu_read, gpu_write, gpu_addr, rsp1_valid, rsp_data} !== {2'b10, 18'h00051, 1'b1, sram_model(18'h00050)}) begin
            n_bad++; $display("FAIL blank_beat2: got rw=%b addr=%h rsp1=%b data=%h", {gpu_read, gpu_write},
                              gpu_addr, rsp1_valid, rsp_data);
        end
        // Video rises while the beat-2 read is on the SRAM port.
        video_on = 1'b1;
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 18'h00060; req0_wdata = 16'h6060;
        req1_addr = 18'h00052;
        #1;
        n_cmp++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            n_bad++; $display("FAIL blank_ready_drop: got %b expected 00", {req0_ready, req1_ready});
        end
        @(negedge clk);
        n_cmp++;
        if ({gpu_read, gpu_write, rsp0_valid, rsp1_valid, rsp_data} !== {4'b0001, sram_model(18'h00051)}) begin
            n_bad++; $display("FAIL blank_inflight_rsp: got rw=%b rsp=%b data=%h expected rw=00 rsp=01 data=%h",
                              {gpu_read, gpu_write}, {rsp0_valid, rsp1_valid}, rsp_data, sram_model(18'h00051));
        end
        #1;
        n_cmp++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            n_bad++; $display("FAIL blank_ready_hold: got %b expected 00", {req0_ready, req1_ready});
        end
        @(negedge clk);
        n_cmp++;
        if ({gpu_read, gpu_write, rsp0_valid, rsp1_valid} !== 4'b0000) begin
            n_bad++; $display("FAIL blank_quiet: got rw=%b rsp=%b expected 0000",
                              {gpu_read, gpu_write}, {rsp0_valid, rsp1_valid});
        end
        video_on = 1'b0;
        #1;
        n_cmp++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_bad++; $display("FAIL blank_rearb: got %b expected 10", {req0_ready, req1_ready});
        end
        @(negedge clk);
        n_cmp++;
        if ({gpu_read, gpu_write, gpu_addr} !== {2'b01, 18'h00060}) begin
            n_bad++; $display("FAIL blank_rearb_strobe: got rw=%b addr=%h expected rw=01 addr=00060",
                              {gpu_read, gpu_write}, gpu_addr);
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int c = 0; c < 6; c++) begin
            logic              exp_rsp;
            logic [DATA_W-1:0] exp_data;
            req0_valid = (c < 3);
            req0_we    = 1'b0;
            req0_addr  = 18'h00100 + 18'(c);
            @(negedge clk);
            n_cmp++;
            if (gpu_read !== (c < 3)) begin
                n_bad++; $display("FAIL b2b_strobe[%0d]: got %b expected %b", c, gpu_read, (c < 3));
            end
            exp_rsp  = (c >= 1) && (c <= 3);
            exp_data = sram_model(18'h00100 + 18'(c - 1));
            n_cmp++;
            if ({rsp0_valid, rsp1_valid} !== {exp_rsp, 1'b0}) begin
                n_bad++; $display("FAIL b2b_rsp_valid[%0d]: got %b expected %b", c, {rsp0_valid, rsp1_valid}, {exp_rsp, 1'b0});
            end
            if (exp_rsp) begin
                n_cmp++;
                if (rsp_data !== exp_data) begin
                    n_bad++; $display("FAIL b2b_rsp_data[%0d]: got %h expected %h", c, rsp_data, exp_data);
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 18'h00077;
        @(negedge clk);
        n_cmp++;
        if (gpu_read !== 1'b1) begin n_bad++; $display("FAIL rmid_strobe: got %b expected 1", gpu_read); end
        rst_n = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({gpu_read, gpu_write, rsp0_valid, rsp1_valid} !== 4'b0000) begin
                n_bad++; $display("FAIL rmid_quiet[%0d]: got rw=%b rsp=%b expected 0000",
                                  c, {gpu_read, gpu_write}, {rsp0_valid, rsp1_valid});
            end
        end
        idle_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_single_write();
        test_read_return();
        test_round_robin();
        test_burst_bubble();
        test_blanking();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gpu_sram_port_arb.md
# gpu_sram_port_arb

Arbiter and sequencer for the single GPU-SRAM framebuffer port. It shares the port between two pixel engines: requester 0 is the line/triangle rasterizer, requester 1 is the screen-clear/fill engine. Accesses are issued only while `I_VIDEO_ON` is low (blanking). The block sits between the engines and the SRAM controller's GPU interface, and owns `O_GPU_ADDR`, `O_GPU_DATA`, `O_GPU_READ` and `O_GPU_WRITE`.

## Interface
- `ADDR_W`, 18, SRAM word address width.
- `DATA_W`, 16, SRAM data width (4×4-bit RGBA-style pixel).
- `MAX_BURST`, 16, maximum consecutive beats per grant (range 1–255).

Ports:
- `I_CLK`  in  1  clock.
- `I_RST_N`  in  1  reset, asynchronous, active-low.
- `I_VIDEO_ON`  in  1  high during active display; the port is frozen while high.
- `I_REQn_VALID`  in  1  (n = 0, 1) request valid.
- `O_REQn_READY`  out  1  request accepted this cycle when VALID and READY are both high.
- `I_REQn_ADDR`  in  `ADDR_W`  word address.
- `I_REQn_WDATA`  in  `DATA_W`  write data.
- `I_REQn_WE`  in  1  1 = write, 0 = read.
- `O_RSPn_VALID`  out  1  read data valid for requester n.
- `O_RSP_DATA`  out  `DATA_W`  read data, shared by both requesters.
- `I_GPU_DATA`  in  `DATA_W`  SRAM read data.
- `O_GPU_ADDR`  out  `ADDR_W`  SRAM address.
- `O_GPU_DATA`  out  `DATA_W`  SRAM write data.
- `O_GPU_READ`  out  1  SRAM read strobe.
- `O_GPU_WRITE`  out  1  SRAM write strobe.

## Operation
State machine:
- States are IDLE, OWN0 and OWN1.
- Registers:
  - `last`, the last owner; reset value 1, so requester 0 wins first.
  - `beats`, an 8-bit beat counter.
- **IDLE**, with `I_VIDEO_ON` low:
  - Arbitration is combinational. If exactly one requester is valid, it gets READY.
  - If both are valid, requester `!last` gets READY.
  - A transfer moves the FSM to OWNn with `beats` = 1. If `MAX_BURST` is 1, the FSM instead stays in IDLE and sets `last` = n.
- **OWNn**:
  - Only requester n can see READY high; the other requester's READY is 0.
  - A transfer increments `beats`.
  - Return to IDLE and set `last` = n when any of the following occurs:
    - a transfer brings `beats` to `MAX_BURST`;
    - `I_REQn_VALID` is low (a bubble cycle, no transfer);
    - `I_VIDEO_ON` is high.
- While `I_VIDEO_ON` is high:
  - Both READY outputs are 0.
  - The FSM is forced to IDLE on the next edge.
  - A read already in flight still completes.
- Each accepted request produces exactly one SRAM strobe, issued in the cycle after acceptance.
- In cycles with no transfer, both strobes are low and address/data hold their last values.

## Timing
- Handshake is accepted on edge t.
- During cycle t+1:
  - `O_GPU_ADDR` and `O_GPU_DATA` are registered from the winning requester.
  - `O_GPU_WRITE` = WE and `O_GPU_READ` = !WE.
- Read path:
  - `I_GPU_DATA` is sampled at the end of cycle t+1 into `O_RSP_DATA`.
  - `O_RSPn_VALID` is high for exactly one cycle, t+2.
  - Read latency is 2 cycles from the handshake.
  - Back-to-back reads give one response per cycle, with no bubbles.
- Burst boundaries:
  - A burst that ends on `MAX_BURST` switches owner with no idle cycle.
  - A burst that ends on a dropped VALID costs one bubble cycle.
- `O_REQn_READY` depends combinationally on `I_REQn_VALID`, `I_VIDEO_ON` and the FSM state. It does not depend on address or data.
- Reset values: all outputs 0. `O_GPU_ADDR` = 0, `O_GPU_DATA` = 0, both strobes 0, both RSP_VALID 0, `O_RSP_DATA` = 0.
- FSM reset state is IDLE with `beats` = 0.
- Reset asserted mid-operation drops any pending read response. No strobe follows reset release until a new handshake occurs.

## Configuration
- `GPU_ARB_FIXED_PRIO_EN`:
  - **Defined:** in IDLE, requester 0 always wins when both are valid and `last` is ignored. Bursts and `MAX_BURST` behave unchanged, so requester 1 can still finish its current burst.
  - **Undefined (default):** round-robin, as described above.

## Test plan
- **Reset:** assert `I_RST_N` = 0 with requests valid → all outputs 0, READY low. Release → first grant goes to requester 0 when both are valid.
- **Single write:** video off, req0 writes addr 0x00123, data 0xF0F0 → READY high on the same cycle. Next cycle `O_GPU_WRITE` = 1, ADDR = 0x00123, DATA = 0xF0F0. The following cycle both strobes are 0.
- **Read return:** req1 reads addr 0x3FFFF and the model drives `I_GPU_DATA` = 0xABCD → `O_GPU_READ` = 1 at t+1. `O_RSP1_VALID` = 1 with `O_RSP_DATA` = 0xABCD at t+2, and `O_RSP0_VALID` stays 0.
- **Round-robin:** `MAX_BURST` = 4, both requesters continuously valid → 4 beats from req0, 4 from req1, 4 from req0, with no idle strobe cycles between them.
- **Blanking edge:** `I_VIDEO_ON` rises after beat 2 of a req1 burst with a read in flight → READY drops in the same cycle, no new strobes appear, and the read response is still delivered. After video falls, IDLE re-arbitrates and req0 wins.
- **Fixed priority:** with `GPU_ARB_FIXED_PRIO_EN` defined, both requesters valid, `MAX_BURST` = 2 → grants are req0, req0, req0, … and req1 is never granted while req0 stays valid.
